regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (regWrite/writeReg/writeData)

---
 rtl/regfile_wb_arbiter_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the regfile writeback arbiter slice.
// Register numbers mirror the CPU's register defines; only REG_ZERO is used here.
package regfile_wb_arbiter_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;
    localparam int REG_A0   = 4;
    localparam int REG_RA   = 31;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_src_e;

    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin one-hot grant, searching upward from ptr+1; purely combinational.
// Latency 0; no backpressure of its own, an idle request vector yields no grant.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    import regfile_wb_arbiter_pkg::*;

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PTR_W'(rr_wrap(int'(ptr) + k, N));
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the regfile write port plus per-register RAW scoreboard.
// Latency: handshake -> regWrite next cycle; backpressure: req_ready low when frozen or another requester wins.
module regfile_wb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_enable,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_addr,
    input  logic [ADDR_W-1:0]       chk_rs,
    input  logic [ADDR_W-1:0]       chk_rt,
    output logic                    stall,
    output logic                    rsv_err,
    output logic                    regWrite,
    output logic [ADDR_W-1:0]       writeReg,
    output logic [DATA_W-1:0]       writeData
);
    import regfile_wb_arbiter_pkg::*;

    localparam int               PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int               NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] ZERO_R = ADDR_W'(REG_ZERO);

    logic [PTR_W-1:0]  ptr;
    logic [N_REQ-1:0]  gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req     (req_valid & {N_REQ{wb_enable}}),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to $zero are consumed but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            ptr       <= PTR_W'(N_REQ - 1);
        end else begin
            regWrite <= gnt_vld && (sel_addr != ZERO_R);
            if (gnt_vld) begin
                writeReg  <= sel_addr;
                writeData <= sel_data;
                ptr       <= gnt_idx;
            end
        end
    end

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             rsv_ok;
    logic             sat_hit;

    assign rsv_ok  = rsv_valid && (rsv_addr != ZERO_R);
    assign inc_vec = rsv_ok ? (NREG'(1) << rsv_addr) : '0;
    assign dec_vec = regWrite ? (NREG'(1) << writeReg) : '0;
    assign sat_hit = rsv_ok && (cnt[rsv_addr] == CNT_MAX) && !dec_vec[rsv_addr];

    // Decrement lands at the end of the regWrite cycle, after the regfile commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            rsv_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r] && cnt[r] != CNT_MAX)
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
            if (sat_hit) rsv_err <= 1'b1;
        end
    end

    assign stall = ((chk_rs != ZERO_R) && (cnt[chk_rs] != '0)) ||
                   ((chk_rt != ZERO_R) && (cnt[chk_rt] != '0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a behavioural model.
// Inputs change on negedge; outputs are sampled between edges.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_enable = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic          rsv_valid = 1'b0;
    logic [AW-1:0] rsv_addr = '0;
    logic [AW-1:0] chk_rs = '0;
    logic [AW-1:0] chk_rt = '0;
    logic          stall, rsv_err, regWrite;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .wb_enable(wb_enable),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .chk_rs(chk_rs), .chk_rt(chk_rt),
        .stall(stall), .rsv_err(rsv_err),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
    );

    int checks = 0;
    int errors = 0;

    // requester-side state
    bit            v [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    // behavioural model
    int            m_ptr;
    int            m_cnt [NREG];
    bit            m_err;
    bit            m_wr;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            last_g;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (!wb_enable) return -1;
        for (int k = 1; k <= N; k++) begin
            int i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit exp_stall();
        return (chk_rs != 0 && m_cnt[chk_rs] != 0) || (chk_rt != 0 && m_cnt[chk_rt] != 0);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v[i];
            req_addr[i*AW +: AW]  = a[i];
            req_data[i*DW +: DW]  = d[i];
        end
    endtask

    task automatic model_reset();
        m_ptr = N - 1;
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_err  = 1'b0;
        m_wr   = 1'b0;
        last_g = -1;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0;
            a[i] = '0;
            d[i] = '0;
        end
    endtask

    // One clock: check everything against the model, clock, advance the model.
    task automatic step();
        int g;
        int n;
        drive();
        #1;
        g = exp_grant();
        check_eq("ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
        check_eq("stall", stall, exp_stall());
        check_eq("rsv_err", rsv_err, m_err);
        check_eq("regWrite", regWrite, m_wr);
        if (m_wr) begin
            check_eq("writeReg", writeReg, m_wa);
            check_eq("writeData", writeData, m_wd);
        end
        @(posedge clk);
        for (int r = 0; r < NREG; r++) begin
            n = m_cnt[r] + ((rsv_valid && rsv_addr == r && r != 0) ? 1 : 0)
                         - ((m_wr && m_wa == r) ? 1 : 0);
            if (n < 0) n = 0;
            if (n > CMAX) begin
                n = CMAX;
                m_err = 1'b1;
            end
            m_cnt[r] = n;
        end
        m_wr = 1'b0;
        if (g >= 0) begin
            m_wr  = (a[g] != 0);
            m_wa  = a[g];
            m_wd  = d[g];
            m_ptr = g;
            v[g]  = 1'b0;
        end
        last_g = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rsv_valid = 1'b0;
        wb_enable = 1'b1;
        model_reset();
        drive();
        @(negedge clk);
        check_eq("rst_regWrite", regWrite, 0);
        check_eq("rst_writeReg", writeReg, 0);
        check_eq("rst_writeData", writeData, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_rsv_err", rsv_err, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int order [4] = '{0, 1, 2, 0};

        // 1: single ALU write, one-cycle latency
        do_reset();
        v[0] = 1'b1; a[0] = 5'd8; d[0] = 32'h1234;
        drive(); #1;
        check_eq("t1_ready", req_ready, 3'b001);
        step();
        check_eq("t1_regWrite", regWrite, 1);
        check_eq("t1_writeReg", writeReg, 8);
        check_eq("t1_writeData", writeData, 32'h1234);
        step();
        check_eq("t1_regWrite_off", regWrite, 0);

        // 2: all requesters valid, grant order 0,1,2,0
        do_reset();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = DW'(32'hA0 + i);
        end
        for (int j = 0; j < 4; j++) begin
            drive(); #1;
            check_eq("t2_order", req_ready, 64'd1 << order[j]);
            step();
            check_eq("t2_regWrite", regWrite, 1);
            if (last_g >= 0) v[last_g] = 1'b1;
        end

        // 3: reserve r9, stall until the edge after its write
        do_reset();
        chk_rs = 5'd9; chk_rt = 5'd0;
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        step();
        rsv_valid = 1'b0;
        drive(); #1;
        check_eq("t3_stall_rsv", stall, 1);
        step();
        step();
        v[1] = 1'b1; a[1] = 5'd9; d[1] = 32'h99;
        step();
        check_eq("t3_regWrite", regWrite, 1);
        check_eq("t3_stall_wr", stall, 1);
        step();
        check_eq("t3_stall_clear", stall, 0);

        // 4: saturate r10, sticky error, writes drain one at a time
        do_reset();
        chk_rs = 5'd10; chk_rt = 5'd0;
        rsv_valid = 1'b1; rsv_addr = 5'd10;
        repeat (4) step();
        rsv_valid = 1'b0;
        check_eq("t4_rsv_err", rsv_err, 1);
        check_eq("t4_stall_sat", stall, 1);
        for (int w = 0; w < 3; w++) begin
            v[0] = 1'b1; a[0] = 5'd10; d[0] = DW'(w);
            step();
            step();
            check_eq("t4_stall_drain", stall, (w < 2) ? 1 : 0);
        end
        check_eq("t4_rsv_err_sticky", rsv_err, 1);

        // 5: $zero handling and freeze
        do_reset();
        v[0] = 1'b1; a[0] = 5'd0; d[0] = 32'hFFFF;
        chk_rs = 5'd0; chk_rt = 5'd0;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        step();
        rsv_valid = 1'b0;
        check_eq("t5_regWrite_zero", regWrite, 0);
        check_eq("t5_stall_zero", stall, 0);
        step();
        check_eq("t5_stall_zero2", stall, 0);
        wb_enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = 5'd3; d[i] = DW'(i);
        end
        drive(); #1;
        check_eq("t5_frozen_ready", req_ready, 0);
        step();
        step();
        wb_enable = 1'b1;
        drive(); #1;
        check_eq("t5_ptr_held", req_ready, 3'b010);
        step();

        // 6: asynchronous reset while a write is in flight
        do_reset();
        chk_rs = 5'd5; chk_rt = 5'd0;
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        v[0] = 1'b1; a[0] = 5'd5; d[0] = 32'h55;
        step();
        rsv_valid = 1'b0;
        check_eq("t6_regWrite_pre", regWrite, 1);
        check_eq("t6_stall_pre", stall, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_regWrite_async", regWrite, 0);
        check_eq("t6_stall_async", stall, 0);
        do_reset();

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if (c % 300 == 299) do_reset();
            wb_enable = ($urandom_range(0, 9) != 0);
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = AW'($urandom_range(0, 7));
            chk_rs    = AW'($urandom_range(0, 7));
            chk_rt    = AW'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    a[i] = AW'($urandom_range(0, 7));
                    d[i] = $urandom;
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
